// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller: opcodes, state numbers,
// datapath mux select codes and the control word driven to the datapath.
package multicycle_control_pkg;

  // Opcodes seen in instruction[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Controller states; the numbers are visible on the debug state port
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  // ALU control requests
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B-operand selects
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // Next-PC selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Everything the datapath needs from the controller in one bundle
  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decode: maps the current state (and memory completion for the
// states that wait on memory) to the datapath control word.
module mc_output_decode
  import multicycle_control_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ok,
  output ctrl_t      ctrl
);

  // Control word per state; unused encodings leave everything deasserted
  always_comb begin
    // NOTE: default the whole word first so no path through the case infers a latch.
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_ok;
        ctrl.pc_write  = mem_ok;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord       = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = mem_ok;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.branch     = 1'b1;
        ctrl.pc_src     = PCSRC_ALUOUT;
        ctrl.instr_done = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_src     = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset controller: Moore FSM sequencing fetch, decode and
// the per-class execute/memory/writeback steps, with optional memory waits.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       Branch,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_d;
  logic   mem_ok;
  logic   illegal_d;
  ctrl_t  ctrl;

  // Without wait support every memory access completes in its first cycle
  assign mem_ok = MEM_WAIT_EN ? mem_ready : 1'b1;

  // State register; reset returns to FETCH immediately
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state selection and the DECODE-time illegal opcode flag
  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ok) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_ok) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (mem_ok) state_d = S_FETCH;
      S_EXECUTE: state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  mc_output_decode u_decode (
    .state  (state_q),
    .mem_ok (mem_ok),
    .ctrl   (ctrl)
  );

  // Write enables and pulses are held low for the whole of reset so an
  // interrupted instruction cannot commit anything
  assign PCWrite    = ctrl.pc_write   & ~reset;
  assign IRWrite    = ctrl.ir_write   & ~reset;
  assign RegWrite   = ctrl.reg_write  & ~reset;
  assign MemWrite   = ctrl.mem_write  & ~reset;
  assign Branch     = ctrl.branch     & ~reset;
  assign instr_done = ctrl.instr_done & ~reset;
  assign illegal_op = illegal_d       & ~reset;

  assign IorD     = ctrl.iord;
  assign MemRead  = ctrl.mem_read;
  assign MemtoReg = ctrl.mem_to_reg;
  assign RegDst   = ctrl.reg_dst;
  assign ALUSrcA  = ctrl.alu_src_a;
  assign ALUSrcB  = ctrl.alu_src_b;
  assign ALUOp    = ctrl.alu_op;
  assign PCSrc    = ctrl.pc_src;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed per-cycle vector table, a zero-wait
// instance for cycle counts, and random instruction streams against a
// per-instruction step-list model.
module tb_multicycle_control;

  // Observed word: state, enables {PCWrite,Branch,IorD,MemRead,MemWrite,
  // IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA}, ALUSrcB, ALUOp, PCSrc, done, illegal
  typedef struct packed {
    logic [3:0] st;
    logic [9:0] en;
    logic [1:0] srcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       done;
    logic       ill;
  } obs_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       mr;
    obs_t       exp;
  } vec_t;

  localparam logic [5:0] LW = 6'h23, SW = 6'h2b, RT = 6'h00, BEQ = 6'h04,
                         JMP = 6'h02, ADDI = 6'h08, ILL = 6'h3f;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;

  logic       PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic       RegDst, RegWrite, ALUSrcA, instr_done, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [3:0] state;

  logic       nw_PCWrite, nw_Branch, nw_IorD, nw_MemRead, nw_MemWrite, nw_IRWrite;
  logic       nw_MemtoReg, nw_RegDst, nw_RegWrite, nw_ALUSrcA, nw_instr_done, nw_illegal_op;
  logic [1:0] nw_ALUSrcB, nw_ALUOp, nw_PCSrc;
  logic [3:0] nw_state;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .Branch(Branch), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSrc(PCSrc), .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  // Memory never ready: with waits disabled this must not stall anything
  multicycle_control #(.MEM_WAIT_EN(1'b0)) dut_nowait (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(1'b0),
    .PCWrite(nw_PCWrite), .Branch(nw_Branch), .IorD(nw_IorD), .MemRead(nw_MemRead),
    .MemWrite(nw_MemWrite), .IRWrite(nw_IRWrite), .MemtoReg(nw_MemtoReg),
    .RegDst(nw_RegDst), .RegWrite(nw_RegWrite), .ALUSrcA(nw_ALUSrcA),
    .ALUSrcB(nw_ALUSrcB), .ALUOp(nw_ALUOp), .PCSrc(nw_PCSrc),
    .instr_done(nw_instr_done), .illegal_op(nw_illegal_op), .state(nw_state)
  );

  obs_t got;
  assign got = '{st: state,
                 en: {PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite,
                      MemtoReg, RegDst, RegWrite, ALUSrcA},
                 srcb: ALUSrcB, aluop: ALUOp, pcsrc: PCSrc,
                 done: instr_done, ill: illegal_op};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic obs_t mk(input logic [3:0] st, input logic [9:0] en,
                              input logic [1:0] b, input logic [1:0] a,
                              input logic [1:0] p, input logic d, input logic i);
    obs_t o;
    o.st = st; o.en = en; o.srcb = b; o.aluop = a; o.pcsrc = p; o.done = d; o.ill = i;
    return o;
  endfunction

  vec_t vecs[$];

  task automatic addv(input logic r, input logic [5:0] op, input logic mr, input obs_t e);
    vec_t v;
    v.rst = r; v.op = op; v.mr = mr; v.exp = e;
    vecs.push_back(v);
  endtask

  // ---------------- reference model ----------------
  // An instruction is a list of step numbers; steps 0, 3 and 5 wait for memory.
  int path[$];

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {LW, SW, RT, BEQ, JMP, ADDI};
  endfunction

  task automatic build_path(input logic [5:0] op);
    case (op)
      LW:      path = '{0, 1, 2, 3, 4};
      SW:      path = '{0, 1, 2, 5};
      RT:      path = '{0, 1, 6, 7};
      ADDI:    path = '{0, 1, 9, 10};
      BEQ:     path = '{0, 1, 8};
      JMP:     path = '{0, 1, 11};
      default: path = '{0, 1};
    endcase
  endtask

  function automatic obs_t model_obs(input int step, input logic mr, input logic ill);
    obs_t o = '0;
    o.st = step[3:0];
    case (step)
      0:  begin o.en = mr ? 10'b1001010000 : 10'b0001000000; o.srcb = 2'b01; end
      1:  begin o.srcb = 2'b11; o.ill = ill; end
      2:  begin o.en = 10'b0000000001; o.srcb = 2'b10; end
      3:  o.en = 10'b0011000000;
      4:  begin o.en = 10'b0000001010; o.done = 1'b1; end
      5:  begin o.en = 10'b0010100000; o.done = mr; end
      6:  begin o.en = 10'b0000000001; o.aluop = 2'b10; end
      7:  begin o.en = 10'b0000000110; o.done = 1'b1; end
      8:  begin o.en = 10'b0100000001; o.aluop = 2'b01; o.pcsrc = 2'b01; o.done = 1'b1; end
      9:  begin o.en = 10'b0000000001; o.srcb = 2'b10; end
      10: begin o.en = 10'b0000000010; o.done = 1'b1; end
      11: begin o.en = 10'b1000000000; o.pcsrc = 2'b10; o.done = 1'b1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] legal [6] = '{LW, SW, RT, BEQ, JMP, ADDI};
    logic [5:0] op;
    int r = $urandom_range(0, 6);
    if (r < 6) return legal[r];
    op = 6'($urandom_range(0, 63));
    while (is_legal(op)) op = 6'($urandom_range(0, 63));
    return op;
  endfunction

  localparam logic [9:0] EN_FETCH = 10'b1001010000;
  localparam logic [9:0] EN_FWAIT = 10'b0001000000;

  initial begin
    reset = 1'b1; opcode = LW; mem_ready = 1'b1;

    // ---- directed per-cycle table ----
    // lw, zero waits: 0,1,2,3,4 then back to 0
    addv(1, LW, 1, mk(0, EN_FWAIT, 2'b01, 0, 0, 0, 0));
    addv(0, LW, 1, mk(0, EN_FETCH, 2'b01, 0, 0, 0, 0));
    addv(0, LW, 1, mk(1, 10'b0, 2'b11, 0, 0, 0, 0));
    addv(0, LW, 1, mk(2, 10'b0000000001, 2'b10, 0, 0, 0, 0));
    addv(0, LW, 1, mk(3, 10'b0011000000, 2'b00, 0, 0, 0, 0));
    addv(0, LW, 1, mk(4, 10'b0000001010, 2'b00, 0, 0, 1, 0));
    // sw with a fetch wait, then three MEMWR wait cycles
    addv(0, SW, 0, mk(0, EN_FWAIT, 2'b01, 0, 0, 0, 0));
    addv(0, SW, 1, mk(0, EN_FETCH, 2'b01, 0, 0, 0, 0));
    addv(0, SW, 1, mk(1, 10'b0, 2'b11, 0, 0, 0, 0));
    addv(0, SW, 1, mk(2, 10'b0000000001, 2'b10, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) addv(0, SW, 0, mk(5, 10'b0010100000, 2'b00, 0, 0, 0, 0));
    addv(0, SW, 1, mk(5, 10'b0010100000, 2'b00, 0, 0, 1, 0));
    // R-type
    addv(0, RT, 1, mk(0, EN_FETCH, 2'b01, 0, 0, 0, 0));
    addv(0, RT, 1, mk(1, 10'b0, 2'b11, 0, 0, 0, 0));
    addv(0, RT, 1, mk(6, 10'b0000000001, 2'b00, 2'b10, 0, 0, 0));
    addv(0, RT, 1, mk(7, 10'b0000000110, 2'b00, 0, 0, 1, 0));
    // beq then j
    addv(0, BEQ, 1, mk(0, EN_FETCH, 2'b01, 0, 0, 0, 0));
    addv(0, BEQ, 1, mk(1, 10'b0, 2'b11, 0, 0, 0, 0));
    addv(0, BEQ, 1, mk(8, 10'b0100000001, 2'b00, 2'b01, 2'b01, 1, 0));
    addv(0, JMP, 1, mk(0, EN_FETCH, 2'b01, 0, 0, 0, 0));
    addv(0, JMP, 1, mk(1, 10'b0, 2'b11, 0, 0, 0, 0));
    addv(0, JMP, 1, mk(11, 10'b1000000000, 2'b00, 0, 2'b10, 1, 0));
    // addi
    addv(0, ADDI, 1, mk(0, EN_FETCH, 2'b01, 0, 0, 0, 0));
    addv(0, ADDI, 1, mk(1, 10'b0, 2'b11, 0, 0, 0, 0));
    addv(0, ADDI, 1, mk(9, 10'b0000000001, 2'b10, 0, 0, 0, 0));
    addv(0, ADDI, 1, mk(10, 10'b0000000010, 2'b00, 0, 0, 1, 0));
    // illegal opcode: one flagged DECODE, back to FETCH
    addv(0, ILL, 1, mk(0, EN_FETCH, 2'b01, 0, 0, 0, 0));
    addv(0, ILL, 1, mk(1, 10'b0, 2'b11, 0, 0, 0, 1));
    addv(0, ILL, 0, mk(0, EN_FWAIT, 2'b01, 0, 0, 0, 0));
    // reset while stalled in MEMWR, then a clean restart
    addv(0, SW, 1, mk(0, EN_FETCH, 2'b01, 0, 0, 0, 0));
    addv(0, SW, 1, mk(1, 10'b0, 2'b11, 0, 0, 0, 0));
    addv(0, SW, 1, mk(2, 10'b0000000001, 2'b10, 0, 0, 0, 0));
    addv(0, SW, 0, mk(5, 10'b0010100000, 2'b00, 0, 0, 0, 0));
    addv(1, SW, 0, mk(0, EN_FWAIT, 2'b01, 0, 0, 0, 0));
    addv(1, SW, 1, mk(0, EN_FWAIT, 2'b01, 0, 0, 0, 0));
    addv(0, SW, 1, mk(0, EN_FETCH, 2'b01, 0, 0, 0, 0));
    addv(0, SW, 1, mk(1, 10'b0, 2'b11, 0, 0, 0, 0));

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      reset = vecs[i].rst; opcode = vecs[i].op; mem_ready = vecs[i].mr;
      #1;
      check($sformatf("vec%0d", i), 32'(got), 32'(vecs[i].exp));
      @(posedge clk); #1;
    end

    // ---- zero-wait instance: lw must take exactly 5 cycles ----
    begin
      int exp_st [6] = '{0, 1, 2, 3, 4, 0};
      reset = 1'b1; opcode = LW; mem_ready = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
        #1;
        check($sformatf("nowait_state%0d", c), 32'(nw_state), 32'(exp_st[c]));
        check($sformatf("nowait_done%0d", c), 32'(nw_instr_done), 32'(c == 4));
        @(posedge clk); #1;
      end
    end

    // ---- random instruction stream against the step-list model ----
    begin
      logic [5:0] cur_op;
      int         idx;
      logic       mr;
      int         step;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      cur_op = pick_op();
      build_path(cur_op);
      idx = 0;
      for (int c = 0; c < 800; c++) begin
        mr = ($urandom_range(0, 3) != 0);
        opcode = cur_op; mem_ready = mr;
        step = path[idx];
        #1;
        check($sformatf("rand%0d_op%h_step%0d", c, cur_op, step), 32'(got),
              32'(model_obs(step, mr, !is_legal(cur_op))));
        @(posedge clk); #1;
        if (!((step == 0 || step == 3 || step == 5) && !mr)) idx++;
        if (idx == path.size()) begin
          cur_op = pick_op();
          build_path(cur_op);
          idx = 0;
        end
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
